// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encodings, NK/NR lookups,
// GF(2^8) doubling, FSM state encoding and word-store sizing.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_LEN_128  = 2'd0,
    KEY_LEN_192  = 2'd1,
    KEY_LEN_256  = 2'd2,
    KEY_LEN_RSVD = 2'd3   // decoded as AES-128
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_READY = 2'd2
  } kx_state_e;

  // 4 * (NR_max + 1) words for AES-256.
  localparam int WORDS_MAX = 60;
  localparam int IDX_W     = 6;

  // Key length in 32-bit words.
  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_192: return 4'd6;
      KEY_LEN_256: return 4'd8;
      default:     return 4'd4;
    endcase
  endfunction

  // Number of cipher rounds.
  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_192: return 4'd12;
      KEY_LEN_256: return 4'd14;
      default:     return 4'd10;
    endcase
  endfunction

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_expansion_seq_if.sv
// Request / status / round-key read bundle of the key expansion block.
// master drives requests (controller side), slave is the expansion block.
interface key_expansion_seq_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [3:0]   nr;

  modport master (
    output start, key_len, key, rk_idx,
    input  busy, done, key_valid, rk, nr
  );

  modport slave (
    input  start, key_len, key, rk_idx,
    output busy, done, key_valid, rk, nr
  );
endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, computed as the GF(2^8) inverse (x^254) followed by the
// affine transform, instead of a 256-entry table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 by square-and-multiply; exponent bits 7..1 set, bit 0 clear. 0 maps to 0.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] b;
    r = 8'h01;
    b = x;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] inv;

  // Inverse then affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    inv = ginv(a_i);
    s_o = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/key_expansion_seq.sv
// Sequential AES key expansion: loads the cipher key on start, then generates
// one schedule word per cycle into a 60-word store; round keys are read back
// through a registered port.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ST_IDLE  | no schedule held since reset; waiting for start
//  ST_GEN   | writing w[i], i = NK .. 4*NR+3, one word per cycle
//  ST_READY | schedule complete and readable; a new start reloads
module key_expansion_seq
  import aes_pkg::*;
#(
  parameter int NK_MAX     = 8,
  parameter int RK_LATENCY = 1
) (
  input logic               clk,
  input logic               rst,
  key_expansion_seq_if.slave kx
);

  if (NK_MAX != 8 || RK_LATENCY != 1) begin : g_param_check
    $error("key_expansion_seq supports only NK_MAX=8 and RK_LATENCY=1");
  end

  kx_state_e        state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [2:0]       wrap_q, wrap_d;     // i mod NK, avoids a divider
  logic [7:0]       rcon_q, rcon_d;
  logic [3:0]       nk_q, nk_d;
  logic [3:0]       nr_q, nr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic [127:0]     rk_q, rk_d;

  logic             load_key;
  logic             gen_word;
  logic [3:0]       nk_new;

  logic [31:0]      w_q [WORDS_MAX];

  logic [IDX_W-1:0] prev_idx, back_idx, last_idx, rd_base;
  logic [31:0]      prev_w, back_w, sub_in, sub_out, temp, new_w;

  assign nk_new   = nk_of(kx.key_len);
  assign last_idx = {nr_q, 2'b11};
  assign prev_idx = i_q - 6'd1;
  assign back_idx = i_q - {2'b00, nk_q};

  // Operand fetch and the per-word transform (RotWord/SubWord/Rcon selection).
  always_comb begin
    prev_w = w_q[prev_idx];
    back_w = w_q[back_idx];
    sub_in = (wrap_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    if (wrap_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h000000};
    else if (nk_q == 4'd8 && wrap_q == 3'd4)
      temp = sub_out;
    else
      temp = prev_w;
    new_w = back_w ^ temp;
  end

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .a_i (sub_in[8*b +: 8]),
      .s_o (sub_out[8*b +: 8])
    );
  end

  // Next-state and control decode.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    wrap_d   = wrap_q;
    rcon_d   = rcon_q;
    nk_d     = nk_q;
    nr_d     = nr_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    load_key = 1'b0;
    gen_word = 1'b0;

    case (state_q)
      ST_IDLE, ST_READY: begin
        if (kx.start) begin
          load_key = 1'b1;
          nk_d     = nk_new;
          nr_d     = nr_of(kx.key_len);
          i_d      = {2'b00, nk_new};
          wrap_d   = 3'd0;
          rcon_d   = 8'h01;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          state_d  = ST_GEN;
        end
      end
      ST_GEN: begin
        gen_word = 1'b1;
        if (wrap_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == last_idx) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_READY;
        end else begin
          i_d    = i_q + 6'd1;
          wrap_d = ({1'b0, wrap_q} == nk_q - 4'd1) ? 3'd0 : wrap_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Round-key read mux; base is clamped so out-of-range indices never address past the store.
  always_comb begin
    rd_base = (kx.rk_idx > 4'd14) ? 6'd56 : {kx.rk_idx, 2'b00};
    if (kx.rk_idx > nr_q)
      rk_d = '0;
    else
      rk_d = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      wrap_q  <= '0;
      rcon_q  <= 8'h01;
      nk_q    <= 4'd4;
      nr_q    <= 4'd10;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      wrap_q  <= wrap_d;
      rcon_q  <= rcon_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      rk_q    <= rk_d;
    end
  end

  // Word store: key words on start, one generated word per GEN cycle; never reset.
  always_ff @(posedge clk) begin
    if (load_key) begin
      for (int j = 0; j < NK_MAX; j++) begin
        if (j < int'(nk_new)) w_q[j] <= kx.key[255 - 32*j -: 32];
      end
    end
    if (gen_word) w_q[i_q] <= new_w;
  end

  assign kx.busy      = busy_q;
  assign kx.done      = done_q;
  assign kx.key_valid = valid_q;
  assign kx.rk        = rk_q;
  assign kx.nr        = nr_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq: FIPS-197 key vectors, start-while-busy,
// mid-generation reset and reserved key_len; round-key expectations queued at start.
module tb_key_expansion_seq;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  key_expansion_seq_if u_if ();

  key_expansion_seq #(
    .NK_MAX     (8),
    .RK_LATENCY (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kx  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [3:0]   idx;
    logic [127:0] val;
  } sb_item_t;

  sb_item_t sb[$];

  localparam logic [255:0] K128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                                   128'hdeadbeef_cafef00d_12345678_9abcdef0};
  localparam logic [255:0] K192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b,
                                   64'h01234567_89abcdef};
  localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  localparam logic [127:0] RK128_0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] RK128_1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] RK128_10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] RK192_0  = 128'h8e73b0f7_da0e6452_c810f32b_809079e5;
  localparam logic [127:0] RK192_12 = 128'he98ba06f_448c773c_8ecc7204_01002202;
  localparam logic [127:0] RK256_0  = 128'h603deb10_15ca71be_2b73aef0_857d7781;
  localparam logic [127:0] RK256_1  = 128'h1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [127:0] RK256_14 = 128'hfe4890d1_e6188d0b_046df344_706c631e;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [3:0] idx, input logic [127:0] val);
    sb_item_t it;
    it.tag = tag;
    it.idx = idx;
    it.val = val;
    sb.push_back(it);
  endtask

  // Read back every queued round key; rk is registered, so sample after the next edge.
  task automatic sb_drain();
    sb_item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge clk);
      u_if.rk_idx = it.idx;
      @(posedge clk);
      #1;
      check(it.tag, u_if.rk, it.val);
    end
  endtask

  // Present start for one edge, then scramble key/key_len since they need not be held.
  task automatic do_start(input string tag, input logic [1:0] kl, input logic [255:0] k,
                          input logic [3:0] exp_nr);
    @(negedge clk);
    u_if.start   = 1'b1;
    u_if.key_len = kl;
    u_if.key     = k;
    @(posedge clk);
    #1;
    u_if.start   = 1'b0;
    u_if.key     = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
    u_if.key_len = 2'($urandom_range(0, 3));
    check({tag, "_busy_on_start"}, 128'(u_if.busy), 128'd1);
    check({tag, "_kv_low_on_start"}, 128'(u_if.key_valid), 128'd0);
    check({tag, "_nr_on_start"}, 128'(u_if.nr), 128'(exp_nr));
  endtask

  // Watch a bounded window after the start edge; optionally re-pulse start mid-generation.
  task automatic run_gen(input string tag, input int exp_edges, input int restart_at,
                         input logic [3:0] exp_nr);
    int first_done;
    int first_valid;
    int n_done;
    first_done  = -1;
    first_valid = -1;
    n_done      = 0;
    for (int e = 1; e <= 64; e++) begin
      @(posedge clk);
      #1;
      if (u_if.done) begin
        n_done++;
        if (first_done < 0) first_done = e;
      end
      if (u_if.key_valid && first_valid < 0) first_valid = e;
      if (e == restart_at) begin
        u_if.start   = 1'b1;
        u_if.key_len = 2'd2;
        u_if.key     = K256;
      end else if (e == restart_at + 1) begin
        u_if.start = 1'b0;
      end
    end
    check({tag, "_done_edge"}, 128'(first_done), 128'(exp_edges));
    check({tag, "_valid_edge"}, 128'(first_valid), 128'(exp_edges));
    check({tag, "_done_count"}, 128'(n_done), 128'd1);
    check({tag, "_busy_after"}, 128'(u_if.busy), 128'd0);
    check({tag, "_kv_after"}, 128'(u_if.key_valid), 128'd1);
    check({tag, "_nr_after"}, 128'(u_if.nr), 128'(exp_nr));
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    u_if.start   = 1'b0;
    u_if.key_len = 2'd0;
    u_if.key     = '0;
    u_if.rk_idx  = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 128'(u_if.busy), 128'd0);
    check("rst_done", 128'(u_if.done), 128'd0);
    check("rst_kv", 128'(u_if.key_valid), 128'd0);
    check("rst_rk", u_if.rk, 128'd0);
    check("rst_nr", 128'(u_if.nr), 128'd10);
    @(negedge clk);
    rst = 1'b0;

    // AES-128
    do_start("a128", 2'd0, K128, 4'd10);
    sb_push("a128_rk10", 4'd10, RK128_10);
    sb_push("a128_rk0", 4'd0, RK128_0);
    sb_push("a128_rk1", 4'd1, RK128_1);
    sb_push("a128_rk11_zero", 4'd11, 128'd0);
    run_gen("a128", 40, -10, 4'd10);
    sb_drain();

    // AES-192
    do_start("a192", 2'd1, K192, 4'd12);
    sb_push("a192_rk12", 4'd12, RK192_12);
    sb_push("a192_rk0", 4'd0, RK192_0);
    sb_push("a192_rk13_zero", 4'd13, 128'd0);
    run_gen("a192", 46, -10, 4'd12);
    sb_drain();

    // AES-256
    do_start("a256", 2'd2, K256, 4'd14);
    sb_push("a256_rk14", 4'd14, RK256_14);
    sb_push("a256_rk0", 4'd0, RK256_0);
    sb_push("a256_rk1", 4'd1, RK256_1);
    sb_push("a256_rk15_zero", 4'd15, 128'd0);
    run_gen("a256", 52, -10, 4'd14);
    sb_drain();

    // Start while busy is ignored
    do_start("ign", 2'd0, K128, 4'd10);
    sb_push("ign_rk10", 4'd10, RK128_10);
    sb_push("ign_rk0", 4'd0, RK128_0);
    run_gen("ign", 40, 10, 4'd10);
    sb_drain();

    // Reset in the middle of an AES-192 generation
    @(negedge clk);
    u_if.rk_idx = 4'd0;
    do_start("rstgen", 2'd1, K192, 4'd12);
    repeat (20) @(posedge clk);
    #2;
    check("rstgen_busy_before", 128'(u_if.busy), 128'd1);
    rst = 1'b1;
    #1;
    check("rstgen_busy", 128'(u_if.busy), 128'd0);
    check("rstgen_kv", 128'(u_if.key_valid), 128'd0);
    check("rstgen_done", 128'(u_if.done), 128'd0);
    check("rstgen_rk", u_if.rk, 128'd0);
    check("rstgen_nr", 128'(u_if.nr), 128'd10);
    @(negedge clk);
    rst = 1'b0;
    do_start("rerun", 2'd0, K128, 4'd10);
    sb_push("rerun_rk10", 4'd10, RK128_10);
    sb_push("rerun_rk0", 4'd0, RK128_0);
    run_gen("rerun", 40, -10, 4'd10);
    sb_drain();

    // From READY with reserved key_len 3 behaves as AES-128
    do_start("kl3", 2'd3, K128, 4'd10);
    sb_push("kl3_rk10", 4'd10, RK128_10);
    sb_push("kl3_rk0", 4'd0, RK128_0);
    sb_push("kl3_rk11_zero", 4'd11, 128'd0);
    run_gen("kl3", 40, -10, 4'd10);
    sb_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
